// File: rtl/iir_biquad_cascade.sv
// Cascaded 2nd-order IIR over NUM_CH channels x NUM_STAGES stages, time-multiplexed on one MAC.
// Latency 6*NUM_CH*NUM_STAGES+1 cycles from an accepted tick to out_valid; ticks while busy are dropped and flagged.
module iir_biquad_cascade #(
  parameter int NUM_CH      = 2,
  parameter int NUM_STAGES  = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 18,
  parameter int COEFF_SCALE = 14,
  parameter int COUNT_BITS  = 10,
  localparam int NCOEF      = NUM_STAGES * 5,
  localparam int SEL_W      = (NCOEF > 1) ? $clog2(NCOEF) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [COUNT_BITS-1:0]         div,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  din,
  input  logic                          coeff_we,
  input  logic [SEL_W-1:0]              coeff_sel,
  input  logic signed [COEFF_WIDTH-1:0] coeff_wdata,
  input  logic                          bypass,
  input  logic                          status_clr,
  output logic [NUM_CH*DATA_WIDTH-1:0]  dout,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          sat_flag,
  output logic                          overrun
);

  localparam int DW     = DATA_WIDTH;
  localparam int CW     = COEFF_WIDTH;
  localparam int PROD_W = DW + CW;
  localparam int ACC_W  = DW + CW + 3;
  localparam int NSLOT  = NUM_CH * NUM_STAGES;
  localparam int ST_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W  = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  typedef logic signed [DW-1:0] smp_t;
  typedef logic signed [CW-1:0] cof_t;
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

  localparam cof_t COEF_ONE = cof_t'(2 ** COEFF_SCALE);
  localparam smp_t SMP_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam smp_t SMP_MIN  = {1'b1, {(DW-1){1'b0}}};

  state_t                  state_q, state_d;
  logic [COUNT_BITS-1:0]   cnt_q, cnt_d;
  logic [2:0]              k_q;
  logic [ST_W-1:0]         stg_q;
  logic [CH_W-1:0]         ch_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  smp_t                    stg_out_q;
  smp_t                    din_q [NUM_CH];
  smp_t                    res_q [NUM_CH];
  smp_t                    x1_q [NSLOT];
  smp_t                    x2_q [NSLOT];
  smp_t                    y1_q [NSLOT];
  smp_t                    y2_q [NSLOT];
  cof_t                    shd_q [NCOEF];
  cof_t                    shd_d [NCOEF];
  cof_t                    act_q [NCOEF];
  logic [NUM_CH*DW-1:0]    dout_q;
  logic                    out_valid_q;
  logic                    sat_q, sat_d;
  logic                    ovr_q, ovr_d;

  logic                    tick, busy_w, last_stg, last_ch, neg, fits;
  logic [IDX_W-1:0]        slot;
  logic [SEL_W-1:0]        cidx;
  smp_t                    x0, op, ysat;
  cof_t                    cof;
  logic signed [PROD_W-1:0] c_ext, op_ext, prod;
  logic signed [ACC_W-1:0] term, term_n, y_full;
  logic [ACC_W-DW:0]       y_hi;

  assign tick   = (div != '0) && (cnt_q == div - COUNT_BITS'(1));
  assign cnt_d  = tick ? '0 : cnt_q + COUNT_BITS'(1);
  assign busy_w = (state_q != S_IDLE);

  assign slot     = IDX_W'(ch_q) * IDX_W'(NUM_STAGES) + IDX_W'(stg_q);
  assign cidx     = SEL_W'(stg_q) * SEL_W'(5) + SEL_W'(k_q);
  assign last_stg = (stg_q == ST_W'(NUM_STAGES - 1));
  assign last_ch  = (ch_q == CH_W'(NUM_CH - 1));

  // Stage 0 reads the latched sample; later stages chain off the previous stage output.
  assign x0 = (stg_q == '0) ? din_q[ch_q] : stg_out_q;

  always_comb begin
    op  = x0;
    neg = 1'b0;
    case (k_q)
      3'd1:    op = x1_q[slot];
      3'd2:    op = x2_q[slot];
      3'd3:    begin op = y1_q[slot]; neg = 1'b1; end
      3'd4:    begin op = y2_q[slot]; neg = 1'b1; end
      default: op = x0;
    endcase
  end

  assign cof    = act_q[cidx];
  assign c_ext  = {{(PROD_W-CW){cof[CW-1]}}, cof};
  assign op_ext = {{(PROD_W-DW){op[DW-1]}}, op};
  assign prod   = c_ext * op_ext;
  assign term   = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign term_n = neg ? -term : term;
  assign acc_d  = (k_q == 3'd0) ? term_n : acc_q + term_n;

  // Floor scaling, then clamp whenever the high bits are not a pure sign extension.
  assign y_full = acc_q >>> COEFF_SCALE;
  assign y_hi   = y_full[ACC_W-1:DW-1];
  assign fits   = (&y_hi) | ~(|y_hi);
  assign ysat   = fits ? y_full[DW-1:0] : (y_full[ACC_W-1] ? SMP_MIN : SMP_MAX);

  assign sat_d = ((state_q == S_WB) && !fits) | (sat_q & ~status_clr);
  assign ovr_d = (tick && busy_w) | (ovr_q & ~status_clr);

  always_comb begin
    for (int i = 0; i < NCOEF; i++) shd_d[i] = shd_q[i];
    if (coeff_we && (int'(coeff_sel) < NCOEF)) shd_d[coeff_sel] = coeff_wdata;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tick) state_d = S_MAC;
      S_MAC:   if (k_q == 3'd4) state_d = S_WB;
      S_WB:    state_d = (last_stg && last_ch) ? S_DONE : S_MAC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      k_q         <= '0;
      stg_q       <= '0;
      ch_q        <= '0;
      acc_q       <= '0;
      stg_out_q   <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      ovr_q       <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        din_q[c] <= '0;
        res_q[c] <= '0;
      end
      for (int i = 0; i < NSLOT; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
      for (int i = 0; i < NCOEF; i++) begin
        shd_q[i] <= (i % 5 == 0) ? COEF_ONE : '0;
        act_q[i] <= (i % 5 == 0) ? COEF_ONE : '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      ovr_q       <= ovr_d;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NCOEF; i++) shd_q[i] <= shd_d[i];
      case (state_q)
        S_IDLE: if (tick) begin
          for (int c = 0; c < NUM_CH; c++) din_q[c] <= din[c*DW +: DW];
          // Same-cycle shadow writes are part of the bank that goes live.
          for (int i = 0; i < NCOEF; i++) act_q[i] <= shd_d[i];
          k_q   <= '0;
          stg_q <= '0;
          ch_q  <= '0;
        end
        S_MAC: begin
          acc_q <= acc_d;
          k_q   <= (k_q == 3'd4) ? 3'd0 : k_q + 3'd1;
        end
        S_WB: begin
          x2_q[slot] <= x1_q[slot];
          x1_q[slot] <= x0;
          y2_q[slot] <= y1_q[slot];
          y1_q[slot] <= ysat;
          stg_out_q  <= ysat;
          if (last_stg) begin
            res_q[ch_q] <= ysat;
            stg_q       <= '0;
            ch_q        <= last_ch ? '0 : ch_q + CH_W'(1);
          end else begin
            stg_q <= stg_q + ST_W'(1);
          end
        end
        S_DONE: begin
          for (int c = 0; c < NUM_CH; c++) dout_q[c*DW +: DW] <= bypass ? din_q[c] : res_q[c];
          out_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_w;
  assign sat_flag  = sat_q;
  assign overrun   = ovr_q;

endmodule
